pool_ctrl: RTL and testbench

Fused ReLU + max-pooling stage between the conv1 output RAM and the conv2 input RAM. When enabled by the controller, it reads the HWC-ordered signed 8-bit conv1 results through a synchronous RAM read port. For each channel it computes max(0, window) over each POOL×POOL window and writes the pooled result, HWC-ordered, into the next layer's input RAM. It reports completion through a held `finish` level, in the same style as the convolution controllers.

---
 rtl/pool_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_pool_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pool_ctrl.sv
// pool_ctrl
//   Fused ReLU + max-pool stage between the conv1 output RAM and the conv2
//   input RAM. Scans each POOLxPOOL window per channel through a 1-cycle
//   latency read port, keeps a running signed max seeded at 0 (the ReLU),
//   and writes one pooled byte per output element. Both maps are HWC ordered.
//
// Ports
//   clk      : system clock, rising edge
//   reset    : synchronous, active-low
//   en_ctrl  : run enable level from the controller
//   r_addr   : read address into conv output RAM (registered)
//   r_data   : signed read data, valid one cycle after r_addr
//   w_addr   : write address into next-layer RAM (registered)
//   w_data   : pooled value (registered)
//   en_write : write strobe, one cycle per output element (registered)
//   busy     : high in READ / DRAIN / WRITE
//   finish   : held high in DONE (registered)
module pool_ctrl #(
    parameter int DIM_IN  = 32,
    parameter int DIM_OUT = 16,
    parameter int CH      = 32,
    parameter int POOL    = 2,
    parameter int STRIDE  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_ctrl,
    output logic [15:0] r_addr,
    input  logic [7:0]  r_data,
    output logic [15:0] w_addr,
    output logic [7:0]  w_data,
    output logic        en_write,
    output logic        busy,
    output logic        finish
);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

    state_t             state;
    logic [15:0]        c, ox, oy, wx, wy;
    logic signed [7:0]  acc;

    logic signed [7:0]  rd_s;
    logic signed [7:0]  acc_max;
    logic [15:0]        n_c, n_ox, n_oy, n_wx, n_wy;
    logic               last_k, last_elem;

    // Products are formed in 32-bit int and truncated to the 16-bit bus.
    function automatic logic [15:0] in_addr(input logic [15:0] oy_i, ox_i, c_i, wy_i, wx_i);
        int y, x;
        y = int'(oy_i) * STRIDE + int'(wy_i);
        x = int'(ox_i) * STRIDE + int'(wx_i);
        return 16'((y * DIM_IN + x) * CH + int'(c_i));
    endfunction

    function automatic logic [15:0] out_addr(input logic [15:0] oy_i, ox_i, c_i);
        return 16'((int'(oy_i) * DIM_OUT + int'(ox_i)) * CH + int'(c_i));
    endfunction

    assign rd_s    = r_data;
    assign acc_max = (rd_s > acc) ? rd_s : acc;
    assign busy    = (state == READ) || (state == DRAIN) || (state == WRITE);

    // Next window position (wx fastest) and next output element (c, ox, oy).
    always_comb begin
        n_wx   = wx + 16'd1;
        n_wy   = wy;
        last_k = 1'b0;
        if (wx == 16'(POOL - 1)) begin
            n_wx = 16'd0;
            n_wy = wy + 16'd1;
            last_k = (wy == 16'(POOL - 1));
        end

        n_c  = c + 16'd1;
        n_ox = ox;
        n_oy = oy;
        if (c == 16'(CH - 1)) begin
            n_c = 16'd0;
            if (ox == 16'(DIM_OUT - 1)) begin
                n_ox = 16'd0;
                n_oy = oy + 16'd1;
            end else begin
                n_ox = ox + 16'd1;
            end
        end
        last_elem = (c == 16'(CH - 1)) && (ox == 16'(DIM_OUT - 1)) && (oy == 16'(DIM_OUT - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            c        <= '0;
            ox       <= '0;
            oy       <= '0;
            wx       <= '0;
            wy       <= '0;
            acc      <= '0;
            r_addr   <= '0;
            w_addr   <= '0;
            w_data   <= '0;
            en_write <= 1'b0;
            finish   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    en_write <= 1'b0;
                    finish   <= 1'b0;
                    if (en_ctrl) begin
                        state  <= READ;
                        c      <= '0;
                        ox     <= '0;
                        oy     <= '0;
                        wx     <= '0;
                        wy     <= '0;
                        acc    <= '0;
                        r_addr <= in_addr(16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
                    end
                end

                READ: begin
                    if (!en_ctrl) begin
                        state  <= IDLE;
                        c      <= '0;
                        ox     <= '0;
                        oy     <= '0;
                        wx     <= '0;
                        wy     <= '0;
                        acc    <= '0;
                        r_addr <= '0;
                        w_addr <= '0;
                        w_data <= '0;
                    end else begin
                        // r_data lags r_addr by one cycle: nothing valid yet in k=0.
                        if (!(wx == 16'd0 && wy == 16'd0))
                            acc <= acc_max;
                        if (last_k) begin
                            state <= DRAIN;
                        end else begin
                            wx     <= n_wx;
                            wy     <= n_wy;
                            r_addr <= in_addr(oy, ox, c, n_wy, n_wx);
                        end
                    end
                end

                DRAIN: begin
                    if (!en_ctrl) begin
                        state  <= IDLE;
                        c      <= '0;
                        ox     <= '0;
                        oy     <= '0;
                        wx     <= '0;
                        wy     <= '0;
                        acc    <= '0;
                        r_addr <= '0;
                        w_addr <= '0;
                        w_data <= '0;
                    end else begin
                        // Last window element lands here; fold it straight into the write.
                        acc      <= acc_max;
                        w_data   <= acc_max;
                        w_addr   <= out_addr(oy, ox, c);
                        en_write <= 1'b1;
                        state    <= WRITE;
                    end
                end

                WRITE: begin
                    en_write <= 1'b0;
                    acc      <= '0;
                    wx       <= '0;
                    wy       <= '0;
                    if (!en_ctrl) begin
                        state  <= IDLE;
                        c      <= '0;
                        ox     <= '0;
                        oy     <= '0;
                        r_addr <= '0;
                        w_addr <= '0;
                        w_data <= '0;
                    end else if (last_elem) begin
                        state  <= DONE;
                        finish <= 1'b1;
                    end else begin
                        state  <= READ;
                        c      <= n_c;
                        ox     <= n_ox;
                        oy     <= n_oy;
                        r_addr <= in_addr(n_oy, n_ox, n_c, 16'd0, 16'd0);
                    end
                end

                DONE: begin
                    en_write <= 1'b0;
                    if (!en_ctrl) begin
                        state  <= IDLE;
                        finish <= 1'b0;
                        c      <= '0;
                        ox     <= '0;
                        oy     <= '0;
                        r_addr <= '0;
                        w_addr <= '0;
                        w_data <= '0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_ctrl.sv
module tb_pool_ctrl;
    localparam int DI   = 4;
    localparam int DO   = 2;
    localparam int CH   = 2;
    localparam int P    = 2;
    localparam int S    = 2;
    localparam int NIN  = DI * DI * CH;
    localparam int NOUT = DO * DO * CH;
    localparam int RUN  = DO * DO * CH * (P * P + 2);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en_ctrl = 1'b0;
    logic [15:0] r_addr, w_addr;
    logic [7:0]  r_data, w_data;
    logic        en_write, busy, finish;

    pool_ctrl #(.DIM_IN(DI), .DIM_OUT(DO), .CH(CH), .POOL(P), .STRIDE(S)) dut (
        .clk(clk), .reset(reset), .en_ctrl(en_ctrl),
        .r_addr(r_addr), .r_data(r_data),
        .w_addr(w_addr), .w_data(w_data), .en_write(en_write),
        .busy(busy), .finish(finish)
    );

    always #5 clk = ~clk;

    logic signed [7:0] in_mem [NIN];

    typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
    wr_t wlog[$];

    int   cyc = 0;
    int   bb_err = 0;
    logic prev_we = 1'b0;

    // 1-cycle latency RAM, write logger, back-to-back write monitor
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        r_data  <= (r_addr < 16'(NIN)) ? in_mem[r_addr[4:0]] : 8'h00;
        if (en_write) wlog.push_back('{w_addr, w_data});
        if (en_write && prev_we) bb_err <= bb_err + 1;
        prev_we <= en_write;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: max(0, window) from plain loops over the input map
    function automatic int ref_out(input int oy, input int ox, input int c);
        int m = 0;
        for (int wy = 0; wy < P; wy++)
            for (int wx = 0; wx < P; wx++) begin
                int v = int'(in_mem[((oy * S + wy) * DI + ox * S + wx) * CH + c]);
                if (v > m) m = v;
            end
        return m;
    endfunction

    // Wait for finish, check latency and all writes against the model,
    // then hold en_ctrl for hold_n cycles and drop it.
    task automatic wait_done(input string tag, input int base, input int start, input int hold_n);
        bit seen = 0;
        int n;
        for (int i = 0; i < RUN + 20 && !seen; i++) begin
            @(negedge clk);
            if (finish) seen = 1;
        end
        chk({tag, "_finish_seen"}, int'(seen), 1);
        chk({tag, "_finish_latency"}, cyc - start, RUN);
        n = wlog.size() - base;
        chk({tag, "_write_count"}, n, NOUT);
        for (int i = 0; i < NOUT && i < n; i++) begin
            int c  = i % CH;
            int ox = (i / CH) % DO;
            int oy = i / (CH * DO);
            chk({tag, "_waddr"}, int'(wlog[base + i].a), i);
            chk({tag, "_wdata"}, int'($signed(wlog[base + i].d)), ref_out(oy, ox, c));
        end
        for (int i = 0; i < hold_n; i++) begin
            @(negedge clk);
            chk({tag, "_finish_hold"}, int'(finish), 1);
        end
        en_ctrl = 1'b0;
        @(negedge clk);
        chk({tag, "_finish_clear"}, int'(finish), 0);
        chk({tag, "_busy_idle"}, int'(busy), 0);
    endtask

    task automatic do_run(input string tag, input int hold_n, output int base);
        int start;
        @(negedge clk);
        en_ctrl = 1'b1;
        base = wlog.size();
        @(negedge clk);
        start = cyc;
        chk({tag, "_busy_start"}, int'(busy), 1);
        chk({tag, "_raddr_start"}, int'(r_addr), 0);
        wait_done(tag, base, start, hold_n);
    endtask

    typedef struct { int v0, v1, v2, v3; int exp; } vec_t;
    vec_t tbl[8];

    function automatic vec_t mk(input int a, input int b, input int c, input int d, input int e);
        vec_t t;
        t.v0 = a; t.v1 = b; t.v2 = c; t.v3 = d; t.exp = e;
        return t;
    endfunction

    initial begin
        int base, start;
        int exp1[8];

        tbl[0] = mk(-5, 127, -128, 3, 127);
        tbl[1] = mk(-1, -2, -3, -4, 0);
        tbl[2] = mk(-128, -128, -128, -128, 0);
        tbl[3] = mk(0, 0, 0, 0, 0);
        tbl[4] = mk(5, -7, 100, 99, 100);
        tbl[5] = mk(127, 127, 127, 127, 127);
        tbl[6] = mk(1, 2, 3, 4, 4);
        tbl[7] = mk(9, 1, 1, 1, 9);
        exp1[0] = 11; exp1[1] = 12; exp1[2] = 13; exp1[3] = 14;
        exp1[4] = 31; exp1[5] = 32; exp1[6] = 33; exp1[7] = 34;

        for (int i = 0; i < NIN; i++) in_mem[i] = 8'sd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_raddr", int'(r_addr), 0);
        chk("rst_waddr", int'(w_addr), 0);
        chk("rst_wdata", int'(w_data), 0);
        chk("rst_enw", int'(en_write), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_finish", int'(finish), 0);
        reset = 1'b1;
        @(negedge clk);

        // 1. Basic pooling, then 4. handshake rerun
        for (int y = 0; y < DI; y++)
            for (int x = 0; x < DI; x++)
                for (int c = 0; c < CH; c++)
                    in_mem[(y * DI + x) * CH + c] = 8'(10 * y + x + c);
        for (int r = 0; r < 2; r++) begin
            do_run(r == 0 ? "basic" : "rerun", 5, base);
            for (int i = 0; i < NOUT && base + i < wlog.size(); i++)
                chk("basic_const", int'($signed(wlog[base + i].d)), exp1[i]);
        end

        // 2. ReLU clamp
        for (int i = 0; i < NIN; i++) in_mem[i] = -8'sd128;
        in_mem[2] = -8'sd1;
        do_run("relu", 1, base);
        for (int i = 0; i < NOUT && base + i < wlog.size(); i++)
            chk("relu_zero", int'(wlog[base + i].d), 0);

        // 3. Table of window (0,0) c=1 contents; other inputs random
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NIN; i++) in_mem[i] = 8'($urandom);
            in_mem[1]  = 8'(tbl[t].v0);
            in_mem[3]  = 8'(tbl[t].v1);
            in_mem[9]  = 8'(tbl[t].v2);
            in_mem[11] = 8'(tbl[t].v3);
            do_run("table", 1, base);
            if (base + 1 < wlog.size())
                chk("table_addr1", int'($signed(wlog[base + 1].d)), tbl[t].exp);
        end

        // Random maps
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < NIN; i++) in_mem[i] = 8'($urandom_range(0, 255));
            do_run("random", 2, base);
        end

        // 5. Abort in 3rd READ cycle of element 2
        @(negedge clk);
        en_ctrl = 1'b1;
        base = wlog.size();
        @(negedge clk);
        repeat (14) @(negedge clk);
        chk("abort_busy_before", int'(busy), 1);
        en_ctrl = 1'b0;
        @(negedge clk);
        chk("abort_busy_after", int'(busy), 0);
        repeat (10) @(negedge clk);
        chk("abort_write_count", wlog.size() - base, 2);
        chk("abort_enw", int'(en_write), 0);
        do_run("after_abort", 1, base);

        // 6. Reset pulse during WRITE of element 0
        @(negedge clk);
        en_ctrl = 1'b1;
        @(negedge clk);
        repeat (5) @(negedge clk);
        chk("rstmid_in_write", int'(en_write), 1);
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_raddr", int'(r_addr), 0);
        chk("rstmid_waddr", int'(w_addr), 0);
        chk("rstmid_wdata", int'(w_data), 0);
        chk("rstmid_enw", int'(en_write), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_finish", int'(finish), 0);
        reset = 1'b1;
        base = wlog.size();
        @(negedge clk);
        start = cyc;
        chk("rstmid_restart_busy", int'(busy), 1);
        chk("rstmid_restart_raddr", int'(r_addr), 0);
        wait_done("rstmid", base, start, 1);

        chk("no_back_to_back_writes", bb_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
